ddr4_pingpong_sched: RTL

- Scheduler between the interleaver write/read engines and the MIG user interface.
- Tracks the two DDR4 ping-pong banks (pages) through FREE/WRITING/FULL/READING and allocates them to the write side and the read side in strict alternation.
- Arbitrates MIG command slots between write bursts and read bursts, holding each grant until its burst has fully issued.

---
 rtl/ddr4_pingpong_sched_if.sv | 41 ++++
 rtl/ddr4_pingpong_sched.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ddr4_pingpong_sched_if.sv
// Signal bundle between the interleaver engines / MIG user interface and the
// ping-pong scheduler. The scheduler takes the slave side.
interface ddr4_pingpong_sched_if #(
  parameter int unsigned BURST_LEN_W = 8
);
  logic                   init_calib_complete;
  logic                   wr_page_req;
  logic                   wr_page_gnt;
  logic                   wr_bank;
  logic                   wr_page_done;
  logic                   rd_page_req;
  logic                   rd_page_gnt;
  logic                   rd_bank;
  logic                   rd_page_done;
  logic                   wr_burst_req;
  logic [BURST_LEN_W-1:0] wr_burst_len;
  logic                   rd_burst_req;
  logic [BURST_LEN_W-1:0] rd_burst_len;
  logic                   app_rdy;
  logic                   app_wdf_rdy;
  logic                   wr_burst_gnt;
  logic                   rd_burst_gnt;
  logic                   burst_beat;
  logic                   burst_done;
  logic [1:0]             bank_full;
  logic                   proto_err;

  modport slave (
    input  init_calib_complete, wr_page_req, wr_page_done, rd_page_req, rd_page_done,
           wr_burst_req, wr_burst_len, rd_burst_req, rd_burst_len, app_rdy, app_wdf_rdy,
    output wr_page_gnt, wr_bank, rd_page_gnt, rd_bank, wr_burst_gnt, rd_burst_gnt,
           burst_beat, burst_done, bank_full, proto_err
  );

  modport master (
    output init_calib_complete, wr_page_req, wr_page_done, rd_page_req, rd_page_done,
           wr_burst_req, wr_burst_len, rd_burst_req, rd_burst_len, app_rdy, app_wdf_rdy,
    input  wr_page_gnt, wr_bank, rd_page_gnt, rd_bank, wr_burst_gnt, rd_burst_gnt,
           burst_beat, burst_done, bank_full, proto_err
  );
endinterface

// File: rtl/ddr4_pingpong_sched.sv
// Ping-pong DDR4 bank allocator plus MIG command-slot arbiter between the
// interleaver write and read engines.
module ddr4_pingpong_sched #(
  parameter int unsigned BURST_LEN_W        = 8,
  parameter int unsigned WR_PRIORITY_BURSTS = 1
) (
  input  logic                        ui_clk,
  input  logic                        ui_clk_sync_rst,
  ddr4_pingpong_sched_if.slave        bus
);
  localparam int unsigned          STREAK_W   = 4;
  localparam logic [STREAK_W-1:0]  STREAK_MAX = '1;
  localparam logic [STREAK_W-1:0]  PRIO       = STREAK_W'(WR_PRIORITY_BURSTS);

  typedef enum logic [1:0] {BANK_FREE, BANK_WRITING, BANK_FULL, BANK_READING} bank_e;
  typedef enum logic [1:0] {ARB_IDLE, ARB_WR, ARB_RD} arb_e;

  bank_e bank_q [2];
  bank_e bank_d [2];
  logic  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic  wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic  wr_page_gnt_q, wr_page_gnt_d, rd_page_gnt_q, rd_page_gnt_d;
  logic  proto_err_q, proto_err_d;
  logic  any_writing, any_reading;

  arb_e                   state_q, state_d;
  logic [BURST_LEN_W-1:0] cnt_q, cnt_d, tgt_q, tgt_d;
  logic [STREAK_W-1:0]    streak_q, streak_d;
  logic                   wr_gnt_q, wr_gnt_d, rd_gnt_q, rd_gnt_d;
  logic                   beat_c, last_c;

  assign any_writing = (bank_q[0] == BANK_WRITING) || (bank_q[1] == BANK_WRITING);
  assign any_reading = (bank_q[0] == BANK_READING) || (bank_q[1] == BANK_READING);

  // Bank lifecycle: done pulses act on the owned bank, grants on the pointed bank
  always_comb begin
    bank_d        = bank_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    wr_page_gnt_d = 1'b0;
    rd_page_gnt_d = 1'b0;
    proto_err_d   = proto_err_q;

    if (bus.wr_page_done) begin
      if (bank_q[wr_bank_q] == BANK_WRITING) bank_d[wr_bank_q] = BANK_FULL;
      else                                   proto_err_d       = 1'b1;
    end
    if (bus.rd_page_done) begin
      if (bank_q[rd_bank_q] == BANK_READING) bank_d[rd_bank_q] = BANK_FREE;
      else                                   proto_err_d       = 1'b1;
    end

    // Grant eligibility looks only at registered state, never at this cycle's dones
    if (bus.init_calib_complete && bus.wr_page_req && !any_writing &&
        bank_q[wr_ptr_q] == BANK_FREE) begin
      wr_page_gnt_d     = 1'b1;
      wr_bank_d         = wr_ptr_q;
      bank_d[wr_ptr_q]  = BANK_WRITING;
      wr_ptr_d          = ~wr_ptr_q;
    end
    if (bus.init_calib_complete && bus.rd_page_req && !any_reading &&
        bank_q[rd_ptr_q] == BANK_FULL) begin
      rd_page_gnt_d     = 1'b1;
      rd_bank_d         = rd_ptr_q;
      bank_d[rd_ptr_q]  = BANK_READING;
      rd_ptr_d          = ~rd_ptr_q;
    end
  end

  assign beat_c = (wr_gnt_q & bus.app_rdy & bus.app_wdf_rdy) | (rd_gnt_q & bus.app_rdy);
  assign last_c = beat_c && (cnt_q == tgt_q - BURST_LEN_W'(1));

  // Command arbiter: a grant is held until its burst's final beat is accepted
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tgt_d    = tgt_q;
    streak_d = streak_q;
    wr_gnt_d = wr_gnt_q;
    rd_gnt_d = rd_gnt_q;

    case (state_q)
      ARB_IDLE: begin
        wr_gnt_d = 1'b0;
        rd_gnt_d = 1'b0;
        if (bus.init_calib_complete && (bus.wr_burst_req || bus.rd_burst_req)) begin
          cnt_d = '0;
          if (bus.rd_burst_req && (!bus.wr_burst_req || streak_q >= PRIO)) begin
            state_d  = ARB_RD;
            rd_gnt_d = 1'b1;
            tgt_d    = (bus.rd_burst_len == '0) ? BURST_LEN_W'(1) : bus.rd_burst_len;
          end else begin
            state_d  = ARB_WR;
            wr_gnt_d = 1'b1;
            tgt_d    = (bus.wr_burst_len == '0) ? BURST_LEN_W'(1) : bus.wr_burst_len;
          end
        end
      end
      ARB_WR, ARB_RD: begin
        if (beat_c) begin
          cnt_d = cnt_q + BURST_LEN_W'(1);
          if (last_c) begin
            state_d  = ARB_IDLE;
            wr_gnt_d = 1'b0;
            rd_gnt_d = 1'b0;
            cnt_d    = '0;
            if (state_q == ARB_WR)
              streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + STREAK_W'(1);
            else
              streak_d = '0;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      bank_q[0]     <= BANK_FREE;
      bank_q[1]     <= BANK_FREE;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      wr_page_gnt_q <= 1'b0;
      rd_page_gnt_q <= 1'b0;
      proto_err_q   <= 1'b0;
      state_q       <= ARB_IDLE;
      cnt_q         <= '0;
      tgt_q         <= '0;
      streak_q      <= '0;
      wr_gnt_q      <= 1'b0;
      rd_gnt_q      <= 1'b0;
    end else begin
      bank_q        <= bank_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      wr_page_gnt_q <= wr_page_gnt_d;
      rd_page_gnt_q <= rd_page_gnt_d;
      proto_err_q   <= proto_err_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tgt_q         <= tgt_d;
      streak_q      <= streak_d;
      wr_gnt_q      <= wr_gnt_d;
      rd_gnt_q      <= rd_gnt_d;
    end
  end

  assign bus.wr_page_gnt  = wr_page_gnt_q;
  assign bus.rd_page_gnt  = rd_page_gnt_q;
  assign bus.wr_bank      = wr_bank_q;
  assign bus.rd_bank      = rd_bank_q;
  assign bus.proto_err    = proto_err_q;
  assign bus.wr_burst_gnt = wr_gnt_q;
  assign bus.rd_burst_gnt = rd_gnt_q;
  assign bus.burst_beat   = beat_c;
  assign bus.burst_done   = last_c;
  assign bus.bank_full    = {bank_q[1] == BANK_FULL, bank_q[0] == BANK_FULL};

endmodule
